// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD-line serialiser/deserialiser pair.
//   state_e        : receiver FSM states
//   CRC7_POLY      : x^7 + x^3 + 1 (the x^7 term is implicit)
//   frame indices  : field positions of a 48-bit command/response frame
//   crc7_step      : one serial CRC7 update, shared by both line directions
package sd_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int unsigned FRAME_N   = 48;
  localparam int unsigned START_BIT = 47;
  localparam int unsigned TX_BIT    = 46;
  localparam int unsigned INDEX_HI  = 45;
  localparam int unsigned INDEX_LO  = 40;
  localparam int unsigned ARG_HI    = 39;
  localparam int unsigned ARG_LO    = 8;
  localparam int unsigned CRC_HI    = 7;
  localparam int unsigned CRC_LO    = 1;
  localparam int unsigned END_BIT   = 0;

  // Shift one bit into a CRC7 register (MSB-first serial form).
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator/checker.
//   clk, reset : clock, synchronous active-high reset
//   clr        : restart from 0 (combined with en, the bit is folded into 0)
//   en         : fold din into the CRC this cycle
//   din        : serial bit
//   crc        : current CRC register
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic [6:0] base;

  // Next CRC value
  always_comb begin
    base  = clr ? 7'h00 : crc_q;
    crc_d = en ? crc7_step(base, din) : base;
  end

  always_ff @(posedge clk) begin
    if (reset) crc_q <= 7'h00;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/cmd_serial_to_parallel.sv
// SD CMD-line receiver: detects a start bit, shifts in an n-bit frame MSB
// first and presents it with a one-cycle valid strobe plus CRC7/end-bit status.
//   sd_clock   : CMD-line clock
//   reset      : synchronous active-high reset
//   enable     : receiver armed; low aborts a frame in progress
//   serial     : CMD line (idles high, start bit 0)
//   parallel   : last completed frame, bit n-1 received first
//   data_valid : one-cycle strobe qualifying parallel/crc_ok/frame_err
//   crc_ok     : CRC7 over [n-1:8] matched [7:1]
//   frame_err  : end bit of last frame was 0
//   busy       : frame reception in progress
module cmd_serial_to_parallel
  import sd_cmd_pkg::*;
#(
  parameter int unsigned n      = 48,
  parameter bit          CRC_EN = 1'b1
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         serial,
  output logic [n-1:0] parallel,
  output logic         data_valid,
  output logic         crc_ok,
  output logic         frame_err,
  output logic         busy
);

  localparam int unsigned CW = $clog2(n);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [n-1:0]   shift_q, shift_d;
  logic [n-1:0]   parallel_q, parallel_d;
  logic           data_valid_q, data_valid_d;
  logic           crc_ok_q, crc_ok_d;
  logic           frame_err_q, frame_err_d;
  logic           busy_q, busy_d;

  logic           crc_clr;
  logic           crc_en;
  logic           crc_din;
  logic [6:0]     crc;

  sd_crc7 u_crc (
    .clk   (sd_clock),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    parallel_d   = parallel_q;
    data_valid_d = 1'b0;
    crc_ok_d     = crc_ok_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;
    crc_din      = serial;

    case (state_q)
      IDLE: begin
        // CRC held at zero while idle so every frame starts clean
        crc_clr = 1'b1;
        if (enable && !serial) begin
          shift_d = {shift_q[n-2:0], 1'b0};
          cnt_d   = CW'(n - 2);
          crc_en  = 1'b1;
          crc_din = 1'b0;
          busy_d  = 1'b1;
          state_d = RECEIVE;
        end
      end

      RECEIVE: begin
        if (!enable) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          // cnt_q is the index of the bit being sampled this cycle
          shift_d = {shift_q[n-2:0], serial};
          crc_en  = (cnt_q >= CW'(ARG_LO));
          if (cnt_q == '0) begin
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      DONE: begin
        data_valid_d = 1'b1;
        parallel_d   = shift_q;
        crc_ok_d     = CRC_EN ? (crc == shift_q[CRC_HI:CRC_LO]) : 1'b1;
        frame_err_d  = ~shift_q[END_BIT];
        busy_d       = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      parallel_q   <= '0;
      data_valid_q <= 1'b0;
      crc_ok_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      parallel_q   <= parallel_d;
      data_valid_q <= data_valid_d;
      crc_ok_q     <= crc_ok_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign parallel   = parallel_q;
  assign data_valid = data_valid_q;
  assign crc_ok     = crc_ok_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cmd_serial_to_parallel.sv
// Bench for cmd_serial_to_parallel (n=48, CRC_EN=1): frames are driven MSB
// first on the falling edge; expected frames go into a scoreboard that a
// falling-edge monitor drains whenever data_valid is seen.
module tb_cmd_serial_to_parallel;

  localparam logic [47:0] CMD0    = 48'h40_0000_0000_95;
  localparam logic [47:0] CMD17   = 48'h51_0000_0000_55;
  localparam logic [47:0] CMD17_F = 48'h51_0000_1000_55;
  localparam logic [47:0] CMD0_E0 = 48'h40_0000_0000_94;

  typedef struct packed {
    logic [47:0] p;
    logic        c;
    logic        e;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        serial;
  logic [47:0] parallel;
  logic        data_valid;
  logic        crc_ok;
  logic        frame_err;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;
  exp_t sb[$];

  cmd_serial_to_parallel #(.n(48), .CRC_EN(1'b1)) dut (
    .sd_clock   (clk),
    .reset      (reset),
    .enable     (enable),
    .serial     (serial),
    .parallel   (parallel),
    .data_valid (data_valid),
    .crc_ok     (crc_ok),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every data_valid pops one expected frame
  always @(negedge clk) begin
    if (!reset && data_valid) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_valid: data_valid=1 with parallel=%h, none required", parallel);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (parallel !== x.p) begin
          tests_failed++;
          $display("FAIL sb_parallel: got %h required %h", parallel, x.p);
        end
        tests_run++;
        if (crc_ok !== x.c) begin
          tests_failed++;
          $display("FAIL sb_crc_ok: got %b required %b (frame %h)", crc_ok, x.c, x.p);
        end
        tests_run++;
        if (frame_err !== x.e) begin
          tests_failed++;
          $display("FAIL sb_frame_err: got %b required %b (frame %h)", frame_err, x.e, x.p);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge of the DONE cycle
  task automatic drive_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      serial = f[i];
      @(negedge clk);
    end
  endtask

  task automatic idle_cycles(input int k);
    serial = 1'b1;
    repeat (k) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL %s: %0d frames never delivered, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; serial = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({parallel, data_valid, crc_ok, frame_err, busy} !== 52'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got p=%h dv=%b c=%b e=%b b=%b required all 0",
               parallel, data_valid, crc_ok, frame_err, busy);
    end
    reset = 1'b0; enable = 1'b1;
    idle_cycles(5);
  endtask

  task automatic test_cmd0;
    sb.push_back('{p: CMD0, c: 1'b1, e: 1'b0});
    serial = CMD0[47];
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_after_start: got %b required 1", busy);
    end
    for (int i = 46; i >= 0; i--) begin
      serial = CMD0[i];
      @(negedge clk);
    end
    // DONE cycle: the edge that sampled bit 0 has passed, no strobe yet
    serial = 1'b1;
    tests_run++;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_early: got dv=%b busy=%b required 0 0", data_valid, busy);
    end
    @(negedge clk);
    tests_run++;
    if (data_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency: got dv=%b one edge after bit 0, required 1", data_valid);
    end
    @(negedge clk);
    tests_run++;
    if (data_valid !== 1'b0 || parallel !== CMD0) begin
      tests_failed++;
      $display("FAIL strobe_width_hold: got dv=%b p=%h required 0 %h", data_valid, parallel, CMD0);
    end
    idle_cycles(3);
    check_drained("cmd0_drained");
  endtask

  task automatic test_crc;
    sb.push_back('{p: CMD17, c: 1'b1, e: 1'b0});
    drive_frame(CMD17);
    idle_cycles(4);
    sb.push_back('{p: CMD17_F, c: 1'b0, e: 1'b0});
    drive_frame(CMD17_F);
    idle_cycles(4);
    sb.push_back('{p: CMD0_E0, c: 1'b1, e: 1'b1});
    drive_frame(CMD0_E0);
    idle_cycles(4);
    check_drained("crc_drained");
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 47; i >= 21; i--) begin
      serial = CMD0[i];
      @(negedge clk);
    end
    serial = CMD0[20];
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({parallel, data_valid, crc_ok, frame_err, busy} !== 52'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_frame: got p=%h dv=%b c=%b e=%b b=%b required all 0",
               parallel, data_valid, crc_ok, frame_err, busy);
    end
    serial = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(60);
    check_drained("reset_abort_no_valid");
    sb.push_back('{p: CMD0, c: 1'b1, e: 1'b0});
    drive_frame(CMD0);
    idle_cycles(4);
    check_drained("reset_then_cmd0");
  endtask

  task automatic test_enable_abort;
    // parallel currently holds CMD0 from the previous task
    sb.push_back('{p: CMD17, c: 1'b1, e: 1'b0});
    drive_frame(CMD17);
    idle_cycles(4);
    for (int i = 47; i >= 31; i--) begin
      serial = CMD0[i];
      @(negedge clk);
    end
    serial = CMD0[30];
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    serial = 1'b1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_busy: got %b required 0", busy);
    end
    idle_cycles(60);
    tests_run++;
    if (parallel !== CMD17) begin
      tests_failed++;
      $display("FAIL abort_hold: got %h required %h", parallel, CMD17);
    end
    // disabled receiver ignores a low line
    enable = 1'b0;
    serial = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL disabled_idle: got busy=%b required 0", busy);
    end
    serial = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    idle_cycles(60);
    check_drained("abort_no_valid");
  endtask

  task automatic test_back_to_back;
    sb.push_back('{p: CMD0, c: 1'b1, e: 1'b0});
    sb.push_back('{p: CMD17, c: 1'b1, e: 1'b0});
    drive_frame(CMD0);
    serial = 1'b1;                   // DONE cycle
    @(negedge clk);
    tests_run++;
    if (data_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first_valid: got %b required 1", data_valid);
    end
    drive_frame(CMD17);              // start bit sampled right after the strobe
    serial = 1'b1;
    @(negedge clk);
    tests_run++;
    if (data_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_second_valid: got %b required 1", data_valid);
    end
    idle_cycles(3);
    check_drained("b2b_drained");

    // start bit during DONE must be ignored
    sb.push_back('{p: CMD0, c: 1'b1, e: 1'b0});
    drive_frame(CMD0);
    serial = 1'b0;
    @(negedge clk);
    serial = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_start_ignored: got busy=%b required 0", busy);
    end
    idle_cycles(60);
    check_drained("done_start_drained");
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    serial = 1'b1;
    test_reset();
    test_cmd0();
    test_crc();
    test_reset_mid_frame();
    test_enable_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
